// File: rtl/video_pkg.sv
// Shared raster timing presets, coordinate width and RGB packing helpers
// for the video timing generator and its axis counters.
package video_pkg;

  localparam int COORD_W   = 12;
  localparam int COORD_MAX = (1 << COORD_W) - 1;

  // 640x480@60
  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_H_FP     = 16;
  localparam int VGA_H_SYNC   = 96;
  localparam int VGA_H_BP     = 48;
  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_V_FP     = 10;
  localparam int VGA_V_SYNC   = 2;
  localparam int VGA_V_BP     = 33;

  // 1280x720@60
  localparam int HD_H_ACTIVE = 1280;
  localparam int HD_H_FP     = 110;
  localparam int HD_H_SYNC   = 40;
  localparam int HD_H_BP     = 220;
  localparam int HD_V_ACTIVE = 720;
  localparam int HD_V_FP     = 5;
  localparam int HD_V_SYNC   = 5;
  localparam int HD_V_BP     = 20;

  typedef logic [23:0] rgb_t;

  function automatic rgb_t pack_rgb(input logic [7:0] r, input logic [7:0] g,
                                    input logic [7:0] b);
    return {r, g, b};
  endfunction

  function automatic logic [7:0] rgb_r(input rgb_t px);
    return px[23:16];
  endfunction

  function automatic logic [7:0] rgb_g(input rgb_t px);
    return px[15:8];
  endfunction

  function automatic logic [7:0] rgb_b(input rgb_t px);
    return px[7:0];
  endfunction

endpackage

// File: rtl/video_axis_counter.sv
// One raster axis: position counter with wrap pulse plus active and sync
// region decodes. Region order along the axis is active, FP, sync, BP.
module video_axis_counter
  import video_pkg::*;
#(
  parameter int ACTIVE = 640,
  parameter int FP     = 16,
  parameter int SYNC   = 96,
  parameter int BP     = 48
) (
  input  logic               clk_sys,
  input  logic               clr,
  input  logic               step,
  output logic [COORD_W-1:0] count,
  output logic               wrap,
  output logic               active,
  output logic               sync
);

  localparam logic [COORD_W-1:0] LAST       = COORD_W'(ACTIVE + FP + SYNC + BP - 1);
  localparam logic [COORD_W-1:0] ACT_END    = COORD_W'(ACTIVE);
  localparam logic [COORD_W-1:0] SYNC_START = COORD_W'(ACTIVE + FP);
  localparam logic [COORD_W-1:0] SYNC_END   = COORD_W'(ACTIVE + FP + SYNC);

  assign wrap   = step && (count == LAST);
  assign active = count < ACT_END;
  assign sync   = (count >= SYNC_START) && (count < SYNC_END);

  always_ff @(posedge clk_sys) begin
    if (clr) begin
      count <= '0;
    end else if (step) begin
      count <= wrap ? '0 : count + COORD_W'(1);
    end
  end

endmodule

// File: rtl/video_timing_gen.sv
// Raster timing generator and pixel pacer: H/V counters feed one output
// register stage so sync, DE, RGB and coordinates leave on the same edge.
module video_timing_gen
  import video_pkg::*;
#(
  parameter int H_ACTIVE = VGA_H_ACTIVE,
  parameter int H_FP     = VGA_H_FP,
  parameter int H_SYNC   = VGA_H_SYNC,
  parameter int H_BP     = VGA_H_BP,
  parameter int V_ACTIVE = VGA_V_ACTIVE,
  parameter int V_FP     = VGA_V_FP,
  parameter int V_SYNC   = VGA_V_SYNC,
  parameter int V_BP     = VGA_V_BP,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0
) (
  input  logic               I_pix_clk,
  input  logic               I_rst,
  input  logic               I_enable,
  input  logic               I_pix_valid,
  input  logic [23:0]        I_pix_data,
  output logic               O_pix_ready,
  input  logic               I_underflow_clr,
  output logic               O_rgb_hs,
  output logic               O_rgb_vs,
  output logic               O_rgb_de,
  output logic [7:0]         O_rgb_r,
  output logic [7:0]         O_rgb_g,
  output logic [7:0]         O_rgb_b,
  output logic [COORD_W-1:0] O_x,
  output logic [COORD_W-1:0] O_y,
  output logic               O_frame_start,
  output logic               O_underflow
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  if (H_TOTAL > COORD_MAX || V_TOTAL > COORD_MAX) begin : g_size_check
    $error("video_timing_gen: H_TOTAL/V_TOTAL exceed the 12-bit counter range");
  end

  logic               run;
  logic [COORD_W-1:0] hc, vc;
  logic               h_wrap, h_active, h_sync;
  logic               v_wrap_unused, v_active, v_sync;
  logic               active;
  rgb_t               rgb_q;

  // Disable and reset both park the raster at (0,0) so re-enable looks like reset release.
  assign run = I_enable & ~I_rst;

  video_axis_counter #(
    .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP)
  ) u_h_counter (
    .clk_sys(I_pix_clk), .clr(~run), .step(1'b1),
    .count(hc), .wrap(h_wrap), .active(h_active), .sync(h_sync)
  );

  video_axis_counter #(
    .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP)
  ) u_v_counter (
    .clk_sys(I_pix_clk), .clr(~run), .step(h_wrap),
    .count(vc), .wrap(v_wrap_unused), .active(v_active), .sync(v_sync)
  );

  assign active      = h_active & v_active;
  assign O_pix_ready = active & run;

  always_ff @(posedge I_pix_clk) begin
    if (!run) begin
      O_rgb_hs      <= ~HS_POL;
      O_rgb_vs      <= ~VS_POL;
      O_rgb_de      <= 1'b0;
      rgb_q         <= '0;
      O_x           <= '0;
      O_y           <= '0;
      O_frame_start <= 1'b0;
    end else begin
      O_rgb_hs      <= h_sync ? HS_POL : ~HS_POL;
      O_rgb_vs      <= v_sync ? VS_POL : ~VS_POL;
      O_rgb_de      <= active;
      rgb_q         <= (active && I_pix_valid) ? I_pix_data : '0;
      O_x           <= hc;
      O_y           <= vc;
      O_frame_start <= (hc == '0) && (vc == '0);
    end
  end

  // Underflow survives disable; a new starve event beats a same-cycle clear.
  always_ff @(posedge I_pix_clk) begin
    if (I_rst) begin
      O_underflow <= 1'b0;
    end else if (run && active && !I_pix_valid) begin
      O_underflow <= 1'b1;
    end else if (I_underflow_clr) begin
      O_underflow <= 1'b0;
    end
  end

  assign O_rgb_r = rgb_r(rgb_q);
  assign O_rgb_g = rgb_g(rgb_q);
  assign O_rgb_b = rgb_b(rgb_q);

endmodule

// File: tb/tb_video_timing_gen.sv
// Scoreboard bench for video_timing_gen on a tiny 14x7 raster: the driver
// pushes expected outputs per cycle, the monitor pops and compares.
module tb_video_timing_gen;

  localparam int HA = 8, HF = 2, HSY = 2, HB = 2;
  localparam int VA = 4, VF = 1, VSY = 1, VB = 1;
  localparam int HT = HA + HF + HSY + HB;   // 14
  localparam int VT = VA + VF + VSY + VB;   // 7

  logic        clk = 1'b0;
  logic        I_rst = 1'b1, I_enable = 1'b1, I_pix_valid = 1'b0, I_underflow_clr = 1'b0;
  logic [23:0] I_pix_data = '0;
  logic        O_pix_ready, O_rgb_hs, O_rgb_vs, O_rgb_de, O_frame_start, O_underflow;
  logic [7:0]  O_rgb_r, O_rgb_g, O_rgb_b;
  logic [11:0] O_x, O_y;

  video_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSY), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSY), .V_BP(VB),
    .HS_POL(1'b0), .VS_POL(1'b0)
  ) dut (
    .I_pix_clk(clk), .I_rst(I_rst), .I_enable(I_enable),
    .I_pix_valid(I_pix_valid), .I_pix_data(I_pix_data), .O_pix_ready(O_pix_ready),
    .I_underflow_clr(I_underflow_clr),
    .O_rgb_hs(O_rgb_hs), .O_rgb_vs(O_rgb_vs), .O_rgb_de(O_rgb_de),
    .O_rgb_r(O_rgb_r), .O_rgb_g(O_rgb_g), .O_rgb_b(O_rgb_b),
    .O_x(O_x), .O_y(O_y), .O_frame_start(O_frame_start), .O_underflow(O_underflow)
  );

  initial forever #5 clk = ~clk;

  typedef struct {
    bit de, hs, vs, fs, uf;
    int x, y;
  } ctl_t;

  typedef struct {
    int rgb, x, y;
  } pix_t;

  ctl_t ctlq[$];
  pix_t pixq[$];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference raster position of the cycle about to be driven.
  int  mh = 0, mv = 0;
  bit  muf = 0;
  int  data_cnt = 0;
  int  hs_cnt = 0;
  bit  clean = 0;
  bit  measure = 0;

  task automatic step(input bit rst, input bit en, input bit valid, input bit clr);
    bit   run, act;
    ctl_t e;
    pix_t p;
    @(negedge clk);
    I_rst = rst; I_enable = en; I_pix_valid = valid; I_underflow_clr = clr;
    I_pix_data = 24'(data_cnt);
    #1;
    run = en && !rst;
    act = run && (mh < HA) && (mv < VA);
    chk("ready", int'(O_pix_ready), int'(act));

    if (run && mh == 0 && mv == 0) begin
      if (clean && measure) chk("handshakes_per_frame", hs_cnt, HA * VA);
      clean  = measure;
      hs_cnt = 0;
    end
    if (!run) clean = 0;
    if (O_pix_ready && valid) hs_cnt++;

    if (act) begin
      p.rgb = valid ? data_cnt : 0;
      p.x = mh; p.y = mv;
      pixq.push_back(p);
      if (valid) data_cnt++;
    end

    if (rst)                muf = 0;
    else if (act && !valid) muf = 1;
    else if (clr)           muf = 0;

    e.de = act;
    e.hs = run ? !(mh >= HA + HF && mh < HA + HF + HSY) : 1'b1;
    e.vs = run ? !(mv >= VA + VF && mv < VA + VF + VSY) : 1'b1;
    e.fs = run && mh == 0 && mv == 0;
    e.x  = run ? mh : 0;
    e.y  = run ? mv : 0;
    e.uf = muf;
    ctlq.push_back(e);

    if (!run) begin
      mh = 0; mv = 0;
    end else if (mh == HT - 1) begin
      mh = 0;
      mv = (mv == VT - 1) ? 0 : mv + 1;
    end else begin
      mh++;
    end
  endtask

  // Monitor: per-cycle control compare, pixel pop on DE, plus period measurements.
  int cyc = 0, hs_fall = -1, vs_fall = -1, de_cnt = 0;
  bit p_hs = 1, p_vs = 1, de_ok = 0;

  always @(negedge clk) begin
    ctl_t e;
    pix_t p;
    if (ctlq.size() > 0) begin
      e = ctlq.pop_front();
      chk("de", int'(O_rgb_de), int'(e.de));
      chk("hs", int'(O_rgb_hs), int'(e.hs));
      chk("vs", int'(O_rgb_vs), int'(e.vs));
      chk("frame_start", int'(O_frame_start), int'(e.fs));
      chk("x", int'(O_x), e.x);
      chk("y", int'(O_y), e.y);
      chk("underflow", int'(O_underflow), int'(e.uf));
      if (O_rgb_de) begin
        if (pixq.size() == 0) begin
          chk("pix_queue_nonempty", 0, 1);
        end else begin
          p = pixq.pop_front();
          chk("pix_rgb", int'({O_rgb_r, O_rgb_g, O_rgb_b}), p.rgb);
          chk("pix_x", int'(O_x), p.x);
          chk("pix_y", int'(O_y), p.y);
        end
      end else begin
        chk("blank_rgb", int'({O_rgb_r, O_rgb_g, O_rgb_b}), 0);
      end
    end

    if (!measure) begin
      hs_fall = -1; vs_fall = -1; de_ok = 0;
    end else begin
      cyc++;
      if (p_hs && !O_rgb_hs) begin
        if (hs_fall >= 0) chk("hs_period", cyc - hs_fall, HT);
        hs_fall = cyc;
      end
      if (!p_hs && O_rgb_hs && hs_fall >= 0) chk("hs_width", cyc - hs_fall, HSY);
      if (p_vs && !O_rgb_vs) begin
        if (vs_fall >= 0) chk("vs_period", cyc - vs_fall, HT * VT);
        vs_fall = cyc;
      end
      if (!p_vs && O_rgb_vs && vs_fall >= 0) chk("vs_width", cyc - vs_fall, HT * VSY);
      if (O_frame_start) begin
        if (de_ok) chk("de_per_frame", de_cnt, HA * VA);
        de_ok = 1; de_cnt = 0;
      end
      if (O_rgb_de) de_cnt++;
    end
    p_hs = O_rgb_hs;
    p_vs = O_rgb_vs;
  end

  initial begin
    int guard;
    // Reset
    repeat (3) step(1, 1, 1, 0);

    // Two clean frames plus enough tail for the second VS pulse
    measure = 1;
    repeat (2 * HT * VT + 20) step(0, 1, 1, 0);
    measure = 0;

    // Underflow at (3,1); set beats clr at (5,2); plain clr at (0,3)
    guard = 0;
    while (!(mh == 0 && mv == 0) && guard < 200) begin step(0, 1, 1, 0); guard++; end
    repeat (HT * VT) begin
      step(0, 1, !((mh == 3 && mv == 1) || (mh == 5 && mv == 2)),
           (mh == 5 && mv == 2) || (mh == 0 && mv == 3));
    end

    // One-cycle reset at hc=5, vc=2
    guard = 0;
    while (!(mh == 5 && mv == 2) && guard < 200) begin step(0, 1, 1, 0); guard++; end
    step(1, 1, 1, 0);
    repeat (100) step(0, 1, 1, 0);

    // Disable mid-line for 50 cycles, then re-enable and measure
    guard = 0;
    while (!(mh == 4 && mv == 1) && guard < 200) begin step(0, 1, 1, 0); guard++; end
    repeat (50) step(0, 0, 1, 0);
    measure = 1;
    repeat (2 * HT * VT + 20) step(0, 1, 1, 0);
    measure = 0;

    repeat (3) @(negedge clk);
    #1;
    chk("pix_queue_drained", pixq.size(), 0);
    chk("ctl_queue_drained", ctlq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
